vend_ctrl_multi: RTL

Parametrised vending-machine controller, successor to the fixed single-product FSM core between the touch front end and the LCD character renderer. It supports N_PROD products with a price table, COIN_N coin denominations, a credit ceiling, an inactivity auto-refund timer and greedy change dispensing over a valid/ready handshake. The LCD-facing status outputs keep their existing names and meanings, so `lcd_rgb_char` connects unchanged when widths match.

---
 rtl/vend_ctrl_multi.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/vend_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module      : vend_ctrl_multi
// Description : Multi-product vending controller with price table, credit
//               ceiling, idle auto-refund and greedy valid/ready change output.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_ctrl_multi #(
    parameter int                      N_PROD      = 8,
    parameter int                      PROD_W      = 4,
    parameter int                      VAL_W       = 11,
    parameter logic [N_PROD*VAL_W-1:0] PRICES      = {11'd25, 11'd20, 11'd15, 11'd12,
                                                      11'd10, 11'd7,  11'd5,  11'd3},
    parameter int                      COIN_N      = 3,
    parameter logic [COIN_N*VAL_W-1:0] COIN_VAL    = {11'd1, 11'd5, 11'd10},
    parameter int                      MAX_CREDIT  = 100,
    parameter int                      TIMEOUT_CYC = 500000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sel_valid,
    input  logic [PROD_W-1:0]           sel_id,
    input  logic                        coin_valid,
    input  logic [$clog2(COIN_N)-1:0]   coin_idx,
    input  logic                        pay_req,
    input  logic                        cancel,
    input  logic                        chg_ready,
    output logic [PROD_W-1:0]           product_number,
    output logic [VAL_W-1:0]            coin_val_sum,
    output logic                        nonenough_flag,
    output logic                        coin_ov_flag,
    output logic                        coin_reject,
    output logic                        if_coin_flag,
    output logic                        if_pay_flag,
    output logic                        if_charge_flag,
    output logic                        vend_valid,
    output logic [PROD_W-1:0]           vend_id,
    output logic                        chg_valid,
    output logic [$clog2(COIN_N)-1:0]   chg_idx,
    output logic                        chg_residue
);

    localparam int IDX_W = $clog2(COIN_N);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_coin     = 3'd1;
    localparam logic [2:0] c_st_vend     = 3'd2;
    localparam logic [2:0] c_st_chg_sel  = 3'd3;
    localparam logic [2:0] c_st_chg_wait = 3'd4;

    localparam logic [VAL_W:0]    c_max_credit = (VAL_W+1)'(MAX_CREDIT);
    localparam logic [31:0]       c_tmo_last   = 32'(TIMEOUT_CYC - 1);
    localparam logic [PROD_W-1:0] c_n_prod     = PROD_W'(N_PROD);

    logic [2:0]        r_state, w_state_nxt;
    logic [VAL_W-1:0]  r_credit, w_credit_nxt;
    logic [PROD_W-1:0] r_prod, w_prod_nxt;
    logic [31:0]       r_tmo, w_tmo_nxt;
    logic              r_nonenough, w_nonenough_nxt;
    logic              r_coin_ov, w_coin_ov_nxt;
    logic              r_coin_reject, w_coin_reject_nxt;
    logic              r_if_coin, w_if_coin_nxt;
    logic              r_if_pay, w_if_pay_nxt;
    logic              r_if_charge, w_if_charge_nxt;
    logic              r_vend_valid, w_vend_valid_nxt;
    logic [PROD_W-1:0] r_vend_id, w_vend_id_nxt;
    logic              r_chg_valid, w_chg_valid_nxt;
    logic [IDX_W-1:0]  r_chg_idx, w_chg_idx_nxt;
    logic              r_chg_residue, w_chg_residue_nxt;

    logic              w_coin_ok;
    logic [VAL_W-1:0]  w_coin_amt;
    logic [VAL_W:0]    w_sum;
    logic              w_fit;
    logic [VAL_W-1:0]  w_price;
    logic              w_pick_ok;
    logic [IDX_W-1:0]  w_pick_idx;
    logic [VAL_W-1:0]  w_chg_amt;
    logic              w_sel_ok;
    logic              w_coin_take;

    // Table lookups: inserted coin, selected price, dispensed coin, and the
    // largest denomination that still fits the remaining credit.
    always_comb begin
        w_coin_ok  = 1'b0;
        w_coin_amt = '0;
        w_chg_amt  = '0;
        for (int i = 0; i < COIN_N; i++) begin
            if (int'(coin_idx) == i) begin
                w_coin_ok  = 1'b1;
                w_coin_amt = COIN_VAL[i*VAL_W +: VAL_W];
            end
            if (int'(r_chg_idx) == i) begin
                w_chg_amt = COIN_VAL[i*VAL_W +: VAL_W];
            end
        end
        w_price = '0;
        for (int k = 1; k <= N_PROD; k++) begin
            if (int'(r_prod) == k) begin
                w_price = PRICES[(k-1)*VAL_W +: VAL_W];
            end
        end
        w_pick_ok  = 1'b0;
        w_pick_idx = '0;
        for (int i = COIN_N - 1; i >= 0; i--) begin
            if (COIN_VAL[i*VAL_W +: VAL_W] <= r_credit) begin
                w_pick_ok  = 1'b1;
                w_pick_idx = IDX_W'(i);
            end
        end
    end

    assign w_sum       = {1'b0, r_credit} + {1'b0, w_coin_amt};
    assign w_fit       = (w_sum <= c_max_credit);
    assign w_sel_ok    = sel_valid && (sel_id != '0) && (sel_id <= c_n_prod);
    assign w_coin_take = coin_valid && !cancel && !pay_req && w_coin_ok && w_fit;

    always_comb begin
        w_state_nxt       = r_state;
        w_credit_nxt      = r_credit;
        w_prod_nxt        = r_prod;
        w_tmo_nxt         = r_tmo;
        w_nonenough_nxt   = 1'b0;
        w_coin_ov_nxt     = 1'b0;
        w_coin_reject_nxt = 1'b0;
        w_vend_valid_nxt  = 1'b0;
        w_vend_id_nxt     = '0;
        w_chg_valid_nxt   = r_chg_valid;
        w_chg_idx_nxt     = r_chg_idx;
        w_chg_residue_nxt = 1'b0;

        case (r_state)
            c_st_idle: begin
                w_coin_reject_nxt = coin_valid;
                if (w_sel_ok) begin
                    w_prod_nxt  = sel_id;
                    w_tmo_nxt   = '0;
                    w_state_nxt = c_st_coin;
                end
            end
            c_st_coin: begin
                // Any coin not credited this cycle is reported back, whether
                // refused at the ceiling, unknown, or dropped by priority.
                w_coin_reject_nxt = coin_valid && !w_coin_take;
                w_coin_ov_nxt     = coin_valid && !cancel && !pay_req && w_coin_ok && !w_fit;
                if (cancel) begin
                    w_state_nxt = c_st_chg_sel;
                end else if (pay_req) begin
                    w_tmo_nxt = '0;
                    if ({1'b0, r_credit} >= {1'b0, w_price}) begin
                        w_state_nxt      = c_st_vend;
                        w_vend_valid_nxt = 1'b1;
                        w_vend_id_nxt    = r_prod;
                    end else begin
                        w_nonenough_nxt = 1'b1;
                    end
                end else if (w_coin_take) begin
                    w_credit_nxt = w_sum[VAL_W-1:0];
                    w_tmo_nxt    = '0;
                end else if (w_sel_ok && !coin_valid) begin
                    w_prod_nxt = sel_id;
                    w_tmo_nxt  = '0;
                end else if (r_tmo == c_tmo_last) begin
                    w_state_nxt = c_st_chg_sel;
                end else begin
                    w_tmo_nxt = r_tmo + 32'd1;
                end
            end
            c_st_vend: begin
                w_coin_reject_nxt = coin_valid;
                w_credit_nxt      = r_credit - w_price;
                w_state_nxt       = c_st_chg_sel;
            end
            c_st_chg_sel: begin
                w_coin_reject_nxt = coin_valid;
                if (r_credit == '0) begin
                    w_prod_nxt  = '0;
                    w_state_nxt = c_st_idle;
                end else if (w_pick_ok) begin
                    w_chg_valid_nxt = 1'b1;
                    w_chg_idx_nxt   = w_pick_idx;
                    w_state_nxt     = c_st_chg_wait;
                end else begin
                    w_chg_residue_nxt = 1'b1;
                    w_credit_nxt      = '0;
                    w_prod_nxt        = '0;
                    w_state_nxt       = c_st_idle;
                end
            end
            c_st_chg_wait: begin
                w_coin_reject_nxt = coin_valid;
                if (chg_ready) begin
                    w_credit_nxt    = r_credit - w_chg_amt;
                    w_chg_valid_nxt = 1'b0;
                    w_state_nxt     = c_st_chg_sel;
                end
            end
            default: begin
                w_state_nxt     = c_st_idle;
                w_prod_nxt      = '0;
                w_chg_valid_nxt = 1'b0;
            end
        endcase

        w_if_coin_nxt   = (w_state_nxt == c_st_coin);
        w_if_pay_nxt    = (w_state_nxt == c_st_vend);
        w_if_charge_nxt = (w_state_nxt == c_st_chg_sel) || (w_state_nxt == c_st_chg_wait);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_credit      <= '0;
            r_prod        <= '0;
            r_tmo         <= '0;
            r_nonenough   <= 1'b0;
            r_coin_ov     <= 1'b0;
            r_coin_reject <= 1'b0;
            r_if_coin     <= 1'b0;
            r_if_pay      <= 1'b0;
            r_if_charge   <= 1'b0;
            r_vend_valid  <= 1'b0;
            r_vend_id     <= '0;
            r_chg_valid   <= 1'b0;
            r_chg_idx     <= '0;
            r_chg_residue <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_prod        <= w_prod_nxt;
            r_tmo         <= w_tmo_nxt;
            r_nonenough   <= w_nonenough_nxt;
            r_coin_ov     <= w_coin_ov_nxt;
            r_coin_reject <= w_coin_reject_nxt;
            r_if_coin     <= w_if_coin_nxt;
            r_if_pay      <= w_if_pay_nxt;
            r_if_charge   <= w_if_charge_nxt;
            r_vend_valid  <= w_vend_valid_nxt;
            r_vend_id     <= w_vend_id_nxt;
            r_chg_valid   <= w_chg_valid_nxt;
            r_chg_idx     <= w_chg_idx_nxt;
            r_chg_residue <= w_chg_residue_nxt;
        end
    end

    assign product_number = r_prod;
    assign coin_val_sum   = r_credit;
    assign nonenough_flag = r_nonenough;
    assign coin_ov_flag   = r_coin_ov;
    assign coin_reject    = r_coin_reject;
    assign if_coin_flag   = r_if_coin;
    assign if_pay_flag    = r_if_pay;
    assign if_charge_flag = r_if_charge;
    assign vend_valid     = r_vend_valid;
    assign vend_id        = r_vend_id;
    assign chg_valid      = r_chg_valid;
    assign chg_idx        = r_chg_idx;
    assign chg_residue    = r_chg_residue;

endmodule
`default_nettype wire
